// File: rtl/einstein_kbd_matrix.sv
// Einstein keyboard front end: PS/2 Set-2 receiver, scancode decoder,
// 8x8 key matrix and PSG row/column sense with modifier lines.
module einstein_kbd_matrix #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd40000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] kb_row,
    output logic [7:0] kb_col,
    output logic       kb_shift,
    output logic       kb_ctrl,
    output logic       kb_graph,
    output logic [7:0] kb_code,
    output logic       kb_code_valid,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_STOP,
        S_CHECK
    } state_t;

    logic [1:0]             rst_pipe_q;
    logic                   rst_int;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_clk_s;
    logic                   ps2_dat_s;
    logic                   fall;

    state_t      state_q;
    logic [3:0]  bitcnt_q;
    logic [8:0]  sr_q;
    logic        stop_q;
    logic [15:0] tmo_q;
    logic [7:0]  code_q;
    logic        valid_q;
    logic        err_q;
    logic        flush_q;

    logic        ext_q;
    logic        brk_q;
    logic [63:0] keys_q;
    logic [5:0]  mod_q;

    logic        key_hit;
    logic [5:0]  key_idx;
    logic        mod_hit;
    logic [2:0]  mod_idx;

    logic [7:0]  col_d;
    logic [7:0]  col_q;
    logic        shift_q;
    logic        ctrl_q;
    logic        graph_q;

    // Reset asserts immediately, releases two clocks after the input drops
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) rst_pipe_q <= 2'b11;
        else       rst_pipe_q <= {rst_pipe_q[0], 1'b0};
    end

    assign rst_int = rst_pipe_q[1];

    // Bring the asynchronous PS/2 lines into the clk_sys domain
    always_ff @(posedge clk_sys or posedge rst_int) begin
        if (rst_int) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q <= ps2_clk_s;
        end
    end

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall      = clk_prev_q & ~ps2_clk_s;

    // Frame receiver: start, 8 data LSB first, odd parity, stop
    always_ff @(posedge clk_sys or posedge rst_int) begin
        if (rst_int) begin
            state_q  <= S_IDLE;
            bitcnt_q <= 4'd0;
            sr_q     <= 9'd0;
            stop_q   <= 1'b0;
            tmo_q    <= 16'd0;
            code_q   <= 8'h00;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            flush_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        if (!ps2_dat_s) begin
                            state_q  <= S_RECV;
                            bitcnt_q <= 4'd0;
                            tmo_q    <= 16'd0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (fall) begin
                        sr_q     <= {ps2_dat_s, sr_q[8:1]};
                        tmo_q    <= 16'd0;
                        bitcnt_q <= bitcnt_q + 4'd1;
                        if (bitcnt_q == 4'd8) state_q <= S_STOP;
                    end else if (tmo_q == TIMEOUT_CYC) begin
                        state_q <= S_IDLE;
                        flush_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (fall) begin
                        stop_q  <= ps2_dat_s;
                        tmo_q   <= 16'd0;
                        state_q <= S_CHECK;
                    end else if (tmo_q == TIMEOUT_CYC) begin
                        state_q <= S_IDLE;
                        flush_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_CHECK: begin
                    state_q <= S_IDLE;
                    if (stop_q && (^sr_q)) begin
                        code_q  <= sr_q[7:0];
                        valid_q <= 1'b1;
                    end else begin
                        err_q   <= 1'b1;
                        flush_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Scancode to matrix position and modifier slot lookup
    always_comb begin
        key_hit = 1'b0;
        key_idx = 6'd0;
        mod_hit = 1'b0;
        mod_idx = 3'd0;
        unique case ({ext_q, code_q})
            9'h01C: begin key_hit = 1'b1; key_idx = 6'd25; end
            9'h029: begin key_hit = 1'b1; key_idx = 6'd0;  end
            9'h175: begin key_hit = 1'b1; key_idx = 6'd50; end
            9'h076: begin key_hit = 1'b1; key_idx = 6'd63; end
            9'h012: begin mod_hit = 1'b1; mod_idx = 3'd0;  end
            9'h059: begin mod_hit = 1'b1; mod_idx = 3'd1;  end
            9'h014: begin mod_hit = 1'b1; mod_idx = 3'd2;  end
            9'h114: begin mod_hit = 1'b1; mod_idx = 3'd3;  end
            9'h011: begin mod_hit = 1'b1; mod_idx = 3'd4;  end
            9'h111: begin mod_hit = 1'b1; mod_idx = 3'd5;  end
            default: ;
        endcase
    end

    // Prefix tracking and key-down state, applied the cycle after a strobe
    always_ff @(posedge clk_sys or posedge rst_int) begin
        if (rst_int) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            keys_q <= 64'd0;
            mod_q  <= 6'd0;
        end else if (flush_q) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else if (valid_q) begin
            if (code_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else if (code_q == 8'hF0) begin
                brk_q <= 1'b1;
            end else if (code_q == 8'hAA || code_q == 8'hFF) begin
                ext_q  <= 1'b0;
                brk_q  <= 1'b0;
                keys_q <= 64'd0;
                mod_q  <= 6'd0;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
                if (key_hit) keys_q[key_idx] <= ~brk_q;
                if (mod_hit) mod_q[mod_idx] <= ~brk_q;
            end
        end
    end

    // Column sense: OR of held keys over every selected row
    always_comb begin
        col_d = 8'hFF;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 8; r++) begin
                if (!kb_row[r] && keys_q[r*8+c]) col_d[c] = 1'b0;
            end
        end
    end

    // Registered column and modifier outputs
    always_ff @(posedge clk_sys or posedge rst_int) begin
        if (rst_int) begin
            col_q   <= 8'hFF;
            shift_q <= 1'b1;
            ctrl_q  <= 1'b1;
            graph_q <= 1'b1;
        end else begin
            col_q   <= col_d;
            shift_q <= ~(mod_q[0] | mod_q[1]);
            ctrl_q  <= ~(mod_q[2] | mod_q[3]);
            graph_q <= ~(mod_q[4] | mod_q[5]);
        end
    end

    assign kb_col        = col_q;
    assign kb_shift      = shift_q;
    assign kb_ctrl       = ctrl_q;
    assign kb_graph      = graph_q;
    assign kb_code       = code_q;
    assign kb_code_valid = valid_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_einstein_kbd_matrix.sv
// Bench for einstein_kbd_matrix: PS/2 frame driver, key-state model
// and a per-cycle comparator on column, modifier and strobe outputs.
module tb_einstein_kbd_matrix;

    localparam logic [15:0] TO = 16'd600;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] kb_row = 8'h00;
    logic [7:0] kb_col;
    logic       kb_shift;
    logic       kb_ctrl;
    logic       kb_graph;
    logic [7:0] kb_code;
    logic       kb_code_valid;
    logic       frame_err;

    einstein_kbd_matrix #(
        .TIMEOUT_CYC(TO),
        .SYNC_STAGES(2)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .kb_row       (kb_row),
        .kb_col       (kb_col),
        .kb_shift     (kb_shift),
        .kb_ctrl      (kb_ctrl),
        .kb_graph     (kb_graph),
        .kb_code      (kb_code),
        .kb_code_valid(kb_code_valid),
        .frame_err    (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    bit stable = 1'b0;
    logic [7:0] exp_q[$];

    // Model: what is held, per the keyboard chart
    bit mk[8][8];
    bit m_ext, m_brk;
    bit lsh, rsh, lct, rct, lal, ral;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h want %02h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_clear();
        foreach (mk[r, c]) mk[r][c] = 1'b0;
        m_ext = 0; m_brk = 0;
        lsh = 0; rsh = 0; lct = 0; rct = 0; lal = 0; ral = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit v;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hAA || b == 8'hFF) begin
            model_clear();
        end else begin
            v = ~m_brk;
            if (!m_ext && b == 8'h1C) mk[3][1] = v;
            if (!m_ext && b == 8'h29) mk[0][0] = v;
            if (m_ext && b == 8'h75) mk[6][2] = v;
            if (!m_ext && b == 8'h76) mk[7][7] = v;
            if (!m_ext && b == 8'h12) lsh = v;
            if (!m_ext && b == 8'h59) rsh = v;
            if (!m_ext && b == 8'h14) lct = v;
            if (m_ext && b == 8'h14) rct = v;
            if (!m_ext && b == 8'h11) lal = v;
            if (m_ext && b == 8'h11) ral = v;
            m_ext = 0; m_brk = 0;
        end
    endtask

    function automatic logic [7:0] exp_col();
        logic [7:0] v = 8'hFF;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (!kb_row[r] && mk[r][c]) v[c] = 1'b0;
        return v;
    endfunction

    // Per-cycle comparator
    always @(negedge clk_sys) begin
        if (kb_code_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL strobe: got kb_code %02h want no strobe",
                         kb_code);
            end else begin
                chk("kb_code", kb_code, exp_q.pop_front());
            end
        end
        if (frame_err === 1'b1) err_seen++;
        if (stable) begin
            chk("kb_col", kb_col, exp_col());
            chk("mods", {5'd0, kb_shift, kb_ctrl, kb_graph},
                {5'd0, ~(lsh | rsh), ~(lct | rct), ~(lal | ral)});
        end
    end

    task automatic ps2_bit(input logic v);
        ps2_data = v;
        #100 ps2_clk = 1'b0;
        #100 ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad);
        logic par;
        par = ~(^b) ^ bad;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(1'b1);
        ps2_data = 1'b1;
    endtask

    task automatic frame(input logic [7:0] b, input bit bad = 1'b0);
        int e0;
        stable = 0;
        e0 = err_seen;
        if (!bad) exp_q.push_back(b);
        send_byte(b, bad);
        repeat (6) @(posedge clk_sys);
        if (bad) begin
            checks++;
            if (err_seen != e0 + 1) begin
                failures++;
                $display("FAIL frame_err: got %0d pulses want 1",
                         err_seen - e0);
            end
            m_ext = 0; m_brk = 0;
        end else begin
            chk("no_err", 8'(err_seen - e0), 8'd0);
            model_byte(b);
        end
        chk("strobe_seen", 8'(exp_q.size()), 8'd0);
        exp_q.delete();
        repeat (2) @(posedge clk_sys);
        #1 stable = 1;
    endtask

    task automatic set_row(input logic [7:0] v);
        stable = 0;
        kb_row = v;
        repeat (3) @(posedge clk_sys);
        #1 stable = 1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_col"}, kb_col, 8'hFF);
        chk({tag, "_mods"}, {5'd0, kb_shift, kb_ctrl, kb_graph}, 8'h07);
        chk({tag, "_code"}, kb_code, 8'h00);
        chk({tag, "_strb"}, {6'd0, kb_code_valid, frame_err}, 8'h00);
    endtask

    initial begin
        bit found;
        int e0;
        model_clear();
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys);
        chk_reset_outputs("rst");
        stable = 1;

        // 'A' on row 3: strobe, then column two cycles later
        set_row(8'hF7);
        found = 0;
        fork
            frame(8'h1C);
            begin
                for (int i = 0; i < 400 && !found; i++) begin
                    @(negedge clk_sys);
                    if (kb_code_valid) found = 1;
                end
                chk("A_strobe", {7'd0, found}, 8'h01);
                @(negedge clk_sys);
                chk("A_col_t1", kb_col, 8'hFF);
                @(negedge clk_sys);
                chk("A_col_t2", kb_col, 8'hFD);
            end
        join
        chk("A_code", kb_code, 8'h1C);
        frame(8'hF0); frame(8'h1C);
        chk("A_rel", kb_col, 8'hFF);

        // Extended up arrow on row 6
        set_row(8'hBF);
        frame(8'hE0); frame(8'h75);
        chk("up", kb_col, 8'hFB);
        frame(8'hE0); frame(8'hF0); frame(8'h75);
        chk("up_rel", kb_col, 8'hFF);
        set_row(8'hFE);
        frame(8'h29);
        chk("space", kb_col, 8'hFE);
        frame(8'hF0); frame(8'h29);

        // Parity error leaves matrix alone and drops the break prefix
        set_row(8'hF7);
        frame(8'h1C, 1'b1);
        chk("bad_col", kb_col, 8'hFF);
        frame(8'hF0); frame(8'h1C, 1'b1); frame(8'h1C);
        chk("brk_flush", kb_col, 8'hFD);

        // Three keys across rows, then BAT clears everything
        frame(8'h29); frame(8'h76);
        set_row(8'h76);
        chk("multi", kb_col, 8'h7C);
        frame(8'hAA);
        chk("bat", kb_col, 8'hFF);
        set_row(8'h00);
        chk("bat_all", kb_col, 8'hFF);

        // Modifiers
        frame(8'h12); frame(8'hE0); frame(8'h14);
        chk("mod_on", {5'd0, kb_shift, kb_ctrl, kb_graph}, 8'h01);
        chk("mod_col", kb_col, 8'hFF);
        frame(8'hF0); frame(8'h12);
        chk("mod_sh_rel", {5'd0, kb_shift, kb_ctrl, kb_graph}, 8'h05);

        // Frame abandoned after four bits
        stable = 0;
        e0 = err_seen;
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        ps2_data = 1'b1;
        repeat (int'(TO) + 20) @(posedge clk_sys);
        chk("tmo_err", 8'(err_seen - e0), 8'd0);
        chk("tmo_strb", 8'(exp_q.size()), 8'd0);
        #1 stable = 1;
        frame(8'h29);
        chk("tmo_next", kb_col, 8'hFE);

        // Reset in the middle of a frame
        stable = 0;
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        @(posedge clk_sys);
        #2 reset = 1'b1;
        #1 chk_reset_outputs("mid");
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        model_clear();
        repeat (3) @(posedge clk_sys);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk_sys);
        #1 stable = 1;
        set_row(8'hF7);
        frame(8'h1C);
        chk("post_rst", kb_col, 8'hFD);

        repeat (4) @(posedge clk_sys);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/einstein_kbd_matrix.md
Name: einstein_kbd_matrix

Overview:
Upstream stage of the Einstein top level. Receives raw PS/2 Set-2 frames from the host keyboard and maintains an 8x8 key-down matrix. Also drives the modifier lines. The PSG port A row select (kb_row, active-low) is decoded here into the port B column sense (kb_col, active-low). The result is the matrix the Z80 scans through the AY I/O ports, and it feeds the keyboard-interrupt edge detector.

Parameters:
TIMEOUT_CYC, 16'd40000, clk_sys cycles without a PS/2 falling edge mid-frame before the frame is aborted.
SYNC_STAGES, 2, synchroniser depth on ps2_clk and ps2_data.

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high
ps2_clk  in  1  raw PS/2 clock, async, idle high
ps2_data  in  1  raw PS/2 data, async
kb_row  in  8  row select from PSG port A, active-low, multiple rows may be low
kb_col  out  8  column sense to PSG port B, active-low
kb_shift  out  1  low while L-Shift (12) or R-Shift (59) is held
kb_ctrl  out  1  low while L-Ctrl (14) or R-Ctrl (E0 14) is held
kb_graph  out  1  low while L-Alt (11) or R-Alt (E0 11) is held
kb_code  out  8  last accepted scancode byte
kb_code_valid  out  1  one-cycle strobe when kb_code updates
frame_err  out  1  one-cycle strobe on parity, start or stop error

Behaviour:
- Reset state (async assert, synchronous deassert internally):
  - Matrix all released; kb_col=FF; kb_shift, kb_ctrl, kb_graph = 1.
  - kb_code=00; kb_code_valid=0; frame_err=0.
  - Receiver in IDLE; E0 and F0 prefix flags cleared.
- Input sampling:
  - ps2_clk and ps2_data pass through SYNC_STAGES flops.
  - A falling edge is synced clk 1->0; data is sampled on that cycle.
- Receiver FSM:
  - IDLE:
    - On a falling edge, data=0 -> RECV with bit count 0.
    - data=1 -> frame_err pulse, stay IDLE.
  - RECV:
    - Shift in 8 data bits LSB first, then parity.
    - After the 9th bit -> STOP.
  - STOP:
    - On the next falling edge -> CHECK.
  - CHECK (one cycle):
    - Frame is good when stop=1 and the 8 data bits plus parity have an odd count of ones.
    - Good: kb_code<=byte and kb_code_valid=1 on this cycle; -> IDLE.
    - Bad: frame_err=1, prefix flags cleared, byte discarded; -> IDLE.
  - Timeout:
    - In RECV or STOP, a cycle counter runs and restarts on each falling edge.
    - When it reaches TIMEOUT_CYC -> IDLE, with no strobe and prefix flags cleared.
- Decoder (acts on kb_code_valid):
  - E0: set ext. F0: set brk. Prefixes arrive in the order E0 F0 xx.
  - Any other byte:
    - Look up {ext,byte}. If mapped, set the key (brk=0) or clear it (brk=1).
    - Clear ext and brk in all cases; unmapped codes update nothing else.
  - AA (BAT) or FF (overrun): release all keys and modifiers, clear flags.
  - Matrix/modifier update occurs the cycle after kb_code_valid.
  - Typematic repeats of a held key are idempotent.
- Mapping, {ext,code} -> (row, col):
  - 0 1C 'A' -> (3,1)
  - 0 29 space -> (0,0)
  - 1 75 up -> (6,2)
  - 0 76 Esc -> (7,7)
  - All remaining entries follow the team Einstein keyboard chart.
  - Modifier keys never enter the matrix.
- Column output:
  - Registered: kb_col[c] = 0 if any row r with kb_row[r]=0 has key(r,c) down; else 1.
  - Latency: one clk_sys from a kb_row or matrix change.
  - kb_row=FF -> kb_col=FF.
  - Modifier outputs are registered, with one cycle after the matrix update.
- Mid-operation reset:
  - Any state returns to the reset values immediately.
  - A partial frame is discarded; no strobe is generated.

Test Plan:
- Send frame 1C (start 0, data, parity 0, stop 1) with kb_row=F7.
  - Required: kb_code_valid pulse with kb_code=1C; two cycles later kb_col=FD.
  - Then send F0 1C: kb_col returns to FF.
- Send E0 75 with kb_row=BF.
  - Required: kb_col=FB.
  - Send E0 F0 75: kb_col=FF, ext and brk cleared.
  - A following 29 then maps to (0,0), not an extended key.
- Send 1C with parity bit flipped.
  - Required: frame_err pulse, no kb_code_valid, matrix unchanged.
  - Also send F0 then a bad frame then 1C: 'A' is pressed (brk flag was cleared).
- Hold 1C, 29 and 76; kb_row=76.
  - Required: kb_col=7C.
  - Then send AA: kb_col=FF on all rows.
- Send 12, then E0 14.
  - Required: kb_shift=0, kb_ctrl=0, matrix unaffected.
  - Send F0 12: kb_shift=1 while kb_ctrl stays 0.
- Timeout and reset:
  - Stop ps2_clk after 4 bits for TIMEOUT_CYC+1 cycles: no strobe, FSM in IDLE, next full 29 frame accepted.
  - Assert reset mid-frame: all outputs return to reset values within the same cycle.
